// File: rtl/mux_4to1.sv
// mux_4to1: registered 4-to-1 mux of w-bit operands with a 2-bit select.
// Define MUX4TO1_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module mux_4to1 #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [w-1:0] in_0,
  input  logic [w-1:0] in_1,
  input  logic [w-1:0] in_2,
  input  logic [w-1:0] in_3,
  input  logic [1:0]   sel,
  output logic [w-1:0] out
);
  logic [w-1:0] d_0, d_1, d_2, d_3, out_d, out_q;
  logic [1:0]   d_sel;
`ifdef MUX4TO1_IN_REG_EN
  logic [w-1:0] in_0_q, in_1_q, in_2_q, in_3_q;
  logic [1:0]   sel_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_0_q <= '0;
      in_1_q <= '0;
      in_2_q <= '0;
      in_3_q <= '0;
      sel_q  <= 2'b00;
    end else begin
      in_0_q <= in_0;
      in_1_q <= in_1;
      in_2_q <= in_2;
      in_3_q <= in_3;
      sel_q  <= sel;
    end
  end
  assign {d_0, d_1, d_2, d_3, d_sel} = {in_0_q, in_1_q, in_2_q, in_3_q, sel_q};
`else
  assign {d_0, d_1, d_2, d_3, d_sel} = {in_0, in_1, in_2, in_3, sel};
`endif
  // an X/Z select falls to the default and loads zero
  always_comb begin
    case (d_sel)
      2'b00:   out_d = d_0;
      2'b01:   out_d = d_1;
      2'b10:   out_d = d_2;
      2'b11:   out_d = d_3;
      default: out_d = '0;
    endcase
  end
  always_ff @(posedge clk) out_q <= rst_n ? out_d : '0;
  assign out = out_q;
endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: scoreboard bench driving 8-bit and 16-bit instances side by side.
module tb_mux_4to1;
`ifdef MUX4TO1_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  a8 [4];
  logic [15:0] a16 [4];
  logic [1:0]  s8 = 0, s16 = 0;
  logic [7:0]  out8, e8;
  logic [15:0] out16, e16;
  logic [7:0]  q8 [$];
  logic [15:0] q16 [$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  mux_4to1 #(.w(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_0(a8[0]), .in_1(a8[1]), .in_2(a8[2]), .in_3(a8[3]),
    .sel(s8), .out(out8)
  );
  mux_4to1 #(.w(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_0(a16[0]), .in_1(a16[1]), .in_2(a16[2]), .in_3(a16[3]),
    .sel(s16), .out(out16)
  );

  // reset empties the scoreboard; with the input stage, the first post-reset result is the cleared stage (zero)
  task automatic cycle(input logic r);
    rst_n = r;
    if (!r) begin
      q8.delete();
      q16.delete();
      for (int i = 1; i < LAT; i++) begin
        q8.push_back('0);
        q16.push_back('0);
      end
    end else begin
      q8.push_back(a8[s8]);
      q16.push_back(a16[s16]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a8  = '{8'h7F, 8'h11, 8'h22, 8'h33};
    a16 = '{16'h7FFF, 16'h1111, 16'h2222, 16'h3333};
    s8 = 0;
    s16 = 0;
    for (int i = 0; i < 2; i++) begin
      cycle(0);
      n_chk++; if (out8 === 8'h00) n_pass++; else $display("FAIL reset8 got %h want 00", out8);
      n_chk++; if (out16 === 16'h0000) n_pass++; else $display("FAIL reset16 got %h want 0000", out16);
    end
    for (int i = 0; i < LAT; i++) begin
      cycle(1);
      if (q8.size() == LAT) begin
        e8 = q8.pop_front(); n_chk++;
        if (out8 === e8) n_pass++; else $display("FAIL release8 got %h want %h", out8, e8);
      end
      if (q16.size() == LAT) begin
        e16 = q16.pop_front(); n_chk++;
        if (out16 === e16) n_pass++; else $display("FAIL release16 got %h want %h", out16, e16);
      end
    end
    n_chk++; if (out8 === 8'h7F) n_pass++; else $display("FAIL release8_7f got %h want 7f", out8);
  endtask

  task automatic test_exhaustive;
    a8  = '{8'h80, 8'hFF, 8'h00, 8'h7F};
    a16 = '{16'h8000, 16'h7FFF, 16'hFFFE, 16'd1234};
    for (int i = 0; i < 4 + LAT; i++) begin
      s8 = 2'(i);
      s16 = 2'(3 - i);
      cycle(1);
      if (q8.size() == LAT) begin
        e8 = q8.pop_front(); n_chk++;
        if (out8 === e8) n_pass++; else $display("FAIL exh8 got %0d want %0d", $signed(out8), $signed(e8));
      end
      if (q16.size() == LAT) begin
        e16 = q16.pop_front(); n_chk++;
        if (out16 === e16) n_pass++; else $display("FAIL exh16 got %0d want %0d", $signed(out16), $signed(e16));
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) begin
        a8[k]  = 8'($urandom);
        a16[k] = 16'($urandom);
      end
      s8 = 2'($urandom_range(0, 3));
      s16 = 2'($urandom_range(0, 3));
      cycle(1);
      if (q8.size() == LAT) begin
        e8 = q8.pop_front(); n_chk++;
        if (out8 === e8) n_pass++; else $display("FAIL rand8 got %h want %h", out8, e8);
      end
      if (q16.size() == LAT) begin
        e16 = q16.pop_front(); n_chk++;
        if (out16 === e16) n_pass++; else $display("FAIL rand16 got %h want %h", out16, e16);
      end
    end
  endtask

  task automatic test_mid_reset;
    a8  = '{8'h80, 8'hFF, 8'h05, 8'h7F};
    a16 = '{16'h8000, 16'h7FFF, 16'hFFFE, 16'd1234};
    for (int i = 0; i < 8; i++) begin
      s8 = 2'(i);
      s16 = 2'(i + 1);
      if (i == 3) begin
        cycle(0);
        n_chk++; if (out8 === 8'h00) n_pass++; else $display("FAIL midrst8 got %h want 00", out8);
        n_chk++; if (out16 === 16'h0000) n_pass++; else $display("FAIL midrst16 got %h want 0000", out16);
      end else begin
        cycle(1);
        if (q8.size() == LAT) begin
          e8 = q8.pop_front(); n_chk++;
          if (out8 === e8) n_pass++; else $display("FAIL post8 got %h want %h", out8, e8);
        end
        if (q16.size() == LAT) begin
          e16 = q16.pop_front(); n_chk++;
          if (out16 === e16) n_pass++; else $display("FAIL post16 got %h want %h", out16, e16);
        end
      end
    end
  endtask

  task automatic test_simultaneous;
    a8 = '{8'h40, 8'h01, 8'h05, 8'h02};
    s8 = 0;
    for (int i = 0; i < 1 + LAT; i++) begin
      if (i == 1) begin
        s8 = 2;
        a8[2] = 8'hFA;
      end
      cycle(1);
      if (q8.size() == LAT) begin
        e8 = q8.pop_front(); n_chk++;
        if (out8 === e8) n_pass++; else $display("FAIL simul8 got %0d want %0d", $signed(out8), $signed(e8));
      end
      if (q16.size() == LAT) begin
        e16 = q16.pop_front(); n_chk++;
        if (out16 === e16) n_pass++; else $display("FAIL simul16 got %h want %h", out16, e16);
      end
    end
    n_chk++; if (out8 === 8'hFA) n_pass++; else $display("FAIL simul8_new got %0d want -6", $signed(out8));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_exhaustive();
    test_random();
    test_mid_reset();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
